// File: rtl/mem_ram_ctrl_pkg.sv
// rtl/mem_ram_ctrl_pkg.sv - shared state encodings and default widths for the RAM controller
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

package mem_ram_ctrl_pkg;

   // One-bit encodings kept as plain constants so older tools can share them
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // Number of byte-offset bits below the word index
   function automatic int offset_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/mem_ram_array.sv
// rtl/mem_ram_array.sv - single-port byte-enabled storage with registered read
module mem_ram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   localparam int IDX_W     = $clog2(DEPTH),
   localparam int LANES     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic [LANES-1:0]      be_i,
   input  logic [IDX_W-1:0]      addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   // An enabled access with no lanes selected is a read; otherwise hold the last read word
   always_comb begin
      rdata_d = rdata_q;
      if (en_i && (be_i == '0)) begin
         rdata_d = mem[addr_i];
      end
   end

   // Storage and read register carry no reset so contents survive reset
   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      if (en_i) begin
         for (int i = 0; i < LANES; i++) begin
            if (be_i[i]) begin
               mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ram_ctrl.sv
// rtl/mem_ram_ctrl.sv - request/response RAM controller with zero-fill sweep
module mem_ram_ctrl
   import mem_ram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = `API_DATA_WIDTH,
   parameter int ADDR_WIDTH     = `API_ADDR_WIDTH,
   parameter int DEPTH          = 16384,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req_i,
   output logic                    ready_o,
   input  logic [ADDR_WIDTH-1:0]   address_i,
   input  logic [DATA_WIDTH-1:0]   data_in_i,
   input  logic [DATA_WIDTH/8-1:0] wr_mask_i,
   input  logic                    clear_i,
   output logic                    resp_valid_o,
   output logic [DATA_WIDTH-1:0]   data_out_o,
   output logic                    err_o,
   output logic                    busy_o
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int OFFS  = offset_bits(DATA_WIDTH);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   logic [0:0]            state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic [IDX_W-1:0]      cnt_q, cnt_d;
   logic                  resp_q, resp_d;
   logic                  err_q, err_d;
   logic                  rd_q, rd_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;

   logic                  accept;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  addr_err;
   logic [IDX_W-1:0]      req_idx;

   logic                  arr_en;
   logic [LANES-1:0]      arr_be;
   logic [IDX_W-1:0]      arr_addr;
   logic [DATA_WIDTH-1:0] arr_wdata;
   logic [DATA_WIDTH-1:0] arr_rdata;

   assign accept  = req_i & ready_q;
   assign req_idx = IDX_W'(address_i >> OFFS);

   // Address checks: any byte-offset bit set, or any bit above the word index set
   always_comb begin
      misaligned   = 1'b0;
      out_of_range = 1'b0;
      for (int b = 0; b < OFFS; b++) begin
         misaligned = misaligned | address_i[b];
      end
      for (int b = OFFS + IDX_W; b < ADDR_WIDTH; b++) begin
         out_of_range = out_of_range | address_i[b];
      end
      addr_err = misaligned | out_of_range;
   end

   // Next state, sweep counter, array port steering and response qualifiers
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      arr_en    = 1'b0;
      arr_be    = '0;
      arr_addr  = req_idx;
      arr_wdata = data_in_i;
      resp_d    = accept;
      err_d     = accept & addr_err;
      rd_d      = accept & ~addr_err & (wr_mask_i == '0);

      // busy_q marks an active sweep; it lags state by one cycle out of reset,
      // which makes the visible busy window exactly DEPTH cycles long
      if (busy_q) begin
         arr_en    = 1'b1;
         arr_be    = '1;
         arr_addr  = cnt_q;
         arr_wdata = '0;
         if (cnt_q == IDX_W'(DEPTH - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (accept && !addr_err) begin
         arr_en = 1'b1;
         arr_be = wr_mask_i;
      end

      // A clear arriving with an accepted request lets the request finish first
      if ((state_q == ST_IDLE) && clear_i) begin
         state_d = ST_CLEAR;
      end

      busy_d  = (state_d == ST_CLEAR);
      ready_d = (state_d == ST_IDLE);
   end

   // Read responses show the array word, errors force zero, anything else holds
   always_comb begin
      if (rd_q) begin
         data_out_o = arr_rdata;
      end else if (resp_q && err_q) begin
         data_out_o = '0;
      end else begin
         data_out_o = hold_q;
      end
      hold_d = data_out_o;
   end

   // Control and response registers; reset aborts any sweep or pending response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RESET;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         cnt_q   <= '0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         hold_q  <= hold_d;
      end
   end

   mem_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk     (clk),
      .en_i    (arr_en),
      .be_i    (arr_be),
      .addr_i  (arr_addr),
      .wdata_i (arr_wdata),
      .rdata_o (arr_rdata)
   );

   assign ready_o      = ready_q;
   assign resp_valid_o = resp_q;
   assign err_o        = err_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// tb/tb_mem_ram_ctrl.sv - self-checking bench for mem_ram_ctrl with a word-array reference model
module tb_mem_ram_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_i;
   logic        ready_o;
   logic [31:0] address_i;
   logic [31:0] data_in_i;
   logic [3:0]  wr_mask_i;
   logic        clear_i;
   logic        resp_valid_o;
   logic [31:0] data_out_o;
   logic        err_o;
   logic        busy_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model [16];
   logic [31:0] last_out;
   int          busy_cnt;
   int          resp_cnt;
   logic        saw_ready;

   always #5 clk = ~clk;

   mem_ram_ctrl #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .DEPTH          (16),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_i        (req_i),
      .ready_o      (ready_o),
      .address_i    (address_i),
      .data_in_i    (data_in_i),
      .wr_mask_i    (wr_mask_i),
      .clear_i      (clear_i),
      .resp_valid_o (resp_valid_o),
      .data_out_o   (data_out_o),
      .err_o        (err_o),
      .busy_o       (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
   endtask

   // One request per call; checks the response one cycle after the accepting edge
   task automatic do_req(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic clr);
      logic        bad;
      logic [31:0] exp_out;
      @(negedge clk);
      chk("ready_before_req", {31'b0, ready_o}, 32'd1);
      chk("no_stray_resp", {31'b0, resp_valid_o}, 32'd0);
      req_i     = 1'b1;
      address_i = addr;
      data_in_i = data;
      wr_mask_i = mask;
      clear_i   = clr;
      @(posedge clk);
      #1;
      bad = (addr % 4 != 0) || ((addr / 4) >= 16);
      if (bad) begin
         exp_out = 32'h0;
      end else if (mask == 4'h0) begin
         exp_out = model[addr / 4];
      end else begin
         for (int i = 0; i < 4; i++)
            if (mask[i]) model[addr / 4][i*8 +: 8] = data[i*8 +: 8];
         exp_out = last_out;
      end
      last_out = exp_out;
      chk("resp_valid", {31'b0, resp_valid_o}, 32'd1);
      chk("resp_err", {31'b0, err_o}, {31'b0, bad});
      chk("resp_data", data_out_o, exp_out);
      @(negedge clk);
      req_i   = 1'b0;
      clear_i = 1'b0;
   endtask

   // Counts consecutive busy samples starting at the current sample point
   task automatic measure_busy(output int cnt, output int resps, output logic rdy_after);
      cnt       = 0;
      resps     = 0;
      rdy_after = 1'b0;
      for (int c = 0; c < 64; c++) begin
         if (resp_valid_o) resps++;
         if (busy_o) begin
            cnt++;
         end else if (cnt > 0) begin
            rdy_after = ready_o;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      req_i     = 1'b0;
      clear_i   = 1'b0;
      address_i = 32'h0;
      data_in_i = 32'h0;
      wr_mask_i = 4'h0;
      last_out  = 32'h0;

      // Outputs while held in reset
      #23;
      chk("rst_ready", {31'b0, ready_o}, 32'd0);
      chk("rst_resp", {31'b0, resp_valid_o}, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_data", data_out_o, 32'h0);

      // Sweep after reset release lasts exactly DEPTH cycles
      @(negedge clk);
      reset_n = 1'b1;
      measure_busy(busy_cnt, resp_cnt, saw_ready);
      chk("init_sweep_len", busy_cnt, 32'd16);
      chk("init_ready_after", {31'b0, saw_ready}, 32'd1);
      model_clear();

      do_req(32'h0, 32'h0, 4'h0, 1'b0);

      // Partial-lane overwrite
      do_req(32'h8, 32'hDEADBEEF, 4'hF, 1'b0);
      do_req(32'h8, 32'h000000AA, 4'h1, 1'b0);
      do_req(32'h8, 32'h0, 4'h0, 1'b0);
      chk("merged_word", data_out_o, 32'hDEADBEAA);

      // Range and alignment errors
      do_req(32'h40, 32'h0, 4'h0, 1'b0);
      do_req(32'h6, 32'hFFFFFFFF, 4'hF, 1'b0);
      do_req(32'h4, 32'h0, 4'h0, 1'b0);
      do_req(32'h8, 32'h0, 4'h0, 1'b0);

      // Clear together with a write: write completes, then full sweep
      do_req(32'h4, 32'h12345678, 4'hF, 1'b1);
      measure_busy(busy_cnt, resp_cnt, saw_ready);
      chk("clr_sweep_len", busy_cnt, 32'd16);
      chk("clr_ready_after", {31'b0, saw_ready}, 32'd1);
      model_clear();
      do_req(32'h4, 32'h0, 4'h0, 1'b0);
      do_req(32'h8, 32'h0, 4'h0, 1'b0);

      // Reset in the middle of a sweep, request held high throughout
      @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i   = 1'b0;
      req_i     = 1'b1;
      address_i = 32'h0;
      wr_mask_i = 4'h0;
      repeat (6) @(posedge clk);
      #1;
      chk("mid_sweep_busy", {31'b0, busy_o}, 32'd1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy_o}, 32'd0);
      chk("abort_ready", {31'b0, ready_o}, 32'd0);
      chk("abort_data", data_out_o, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      measure_busy(busy_cnt, resp_cnt, saw_ready);
      chk("restart_sweep_len", busy_cnt, 32'd16);
      chk("restart_no_resp", resp_cnt, 32'd0);
      chk("restart_ready_after", {31'b0, saw_ready}, 32'd1);
      @(negedge clk);
      req_i = 1'b0;
      last_out = 32'h0;
      model_clear();

      // Randomized traffic against the word-array model
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         logic [3:0]  m;
         a = $urandom_range(0, 32'h5F);
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         do_req(a, $urandom, m, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_ram_ctrl.md
MEM_RAM_CTRL -- requirements
Module: mem_ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default `API_ADDR_WIDTH: byte-address width.
REQ-003 Parameter DEPTH, default 16384: number of words; SHALL be a power of two, at least 2.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 means zero-fill the array after reset; 0 means go straight to IDLE.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 req_i  in  1  access request.
REQ-008 ready_o  out  1  controller can accept a request this cycle; registered.
REQ-009 address_i  in  ADDR_WIDTH  byte address; word index = address_i >> log2(DATA_WIDTH/8).
REQ-010 data_in_i  in  DATA_WIDTH  write data.
REQ-011 wr_mask_i  in  DATA_WIDTH/8  byte write enables; all-zero means read.
REQ-012 clear_i  in  1  request a zero-fill of the whole array.
REQ-013 resp_valid_o  out  1  one-cycle pulse completing an accepted request.
REQ-014 data_out_o  out  DATA_WIDTH  read data; meaningful only while resp_valid_o is high for a read.
REQ-015 err_o  out  1  qualifies resp_valid_o: the access was out of range or misaligned.
REQ-016 busy_o  out  1  a clear sweep is in progress.

Function
REQ-017 A request is accepted when req_i and ready_o are both high at a rising edge.
REQ-018 Every accepted request SHALL produce exactly one resp_valid_o pulse in the next cycle (latency 1).
REQ-019 Read: data_out_o SHALL equal the stored word at the accepted index.
REQ-020 Write: for each byte lane i, lane i SHALL be updated only when wr_mask_i[i] is 1; other lanes keep their value; data_out_o keeps its previous value.
REQ-021 Error conditions:
- word index >= DEPTH;
- or address_i low bits (byte offset) nonzero.
REQ-022 On an error: err_o is 1 with the response, no array write occurs, and data_out_o is all zeros.
REQ-023 A read in the cycle after a write to the same word SHALL return the newly written data.
REQ-024 States: CLEAR, IDLE.
REQ-025 CLEAR behaviour: a word counter starting at 0 writes zero to one word per cycle; busy_o is 1; ready_o is 0.
REQ-026 CLEAR exit: after writing word DEPTH-1, the counter returns to 0 and the FSM goes to IDLE in the next cycle.
REQ-027 A full clear SHALL take exactly DEPTH cycles.
REQ-028 IDLE behaviour: ready_o is 1; busy_o is 0.
REQ-029 clear_i high in IDLE moves the FSM to CLEAR at the next edge; ready_o SHALL be 0 from that edge on.
REQ-030 clear_i and an accepted request in the same cycle: the request completes normally (response next cycle), and CLEAR starts at that same next edge.
REQ-031 clear_i is ignored while the FSM is in CLEAR.
REQ-032 req_i while ready_o is 0 SHALL be ignored, with no response and no side effect.

Reset
REQ-033 While reset_n is 0, all outputs SHALL be 0: ready_o, resp_valid_o, err_o, busy_o, data_out_o.
REQ-034 While reset_n is 0, the clear counter SHALL be 0.
REQ-035 Reset state after deassertion: CLEAR when CLEAR_ON_RESET is 1, otherwise IDLE; array contents are not touched by reset itself.
REQ-036 Reset asserted mid-sweep or mid-access SHALL abort the operation: no response is issued, and the sweep restarts from word 0 after deassertion.

Structure
REQ-037 State encodings and the default width macros SHALL live in the shared DEFINITIONS include.
REQ-038 Storage SHALL be the sub-module mem_ram_array:
- one synchronous port;
- byte-enabled write;
- registered read;
- no reset.
REQ-039 The FSM, counter, range and alignment checks, and response logic SHALL live in mem_ram_ctrl.

Verification
REQ-040 Reset, CLEAR_ON_RESET=1, DEPTH=16: busy_o is high for exactly 16 cycles, then ready_o rises; a read of address 0x0 returns 0x00000000 with err_o=0.
REQ-041 Write 0xDEADBEEF mask 0xF to address 0x8, then write 0x000000AA mask 0x1 to address 0x8, then read address 0x8: the read returns 0xDEADBEAA one cycle after acceptance.
REQ-042 DEPTH=16: read address 0x40 returns err_o=1 and data 0; write to address 0x6 returns err_o=1 and no word changes.
REQ-043 clear_i pulsed together with a write of 0x12345678 to address 0x4: the write response arrives, busy_o is high for 16 cycles, and a later read of 0x4 returns 0.
REQ-044 reset_n pulsed low at clear cycle 7: busy_o drops immediately, then a full 16-cycle sweep follows deassertion; req_i held high during the sweep yields no response.
